// File: rtl/ram_stream_reader_pkg.sv
// Shared types and defaults for the RAM stream reader and its output FIFO.
package ram_stream_reader_pkg;

  localparam int DEFAULT_AW         = 16;
  localparam int DEFAULT_DW         = 24;
  localparam int DEFAULT_FIFO_DEPTH = 2;

  // Reader sequencing: IDLE waits for START, READ issues addresses, DRAIN
  // empties the pipeline, DONE pulses for one cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a FIFO occupancy counter able to hold 0..depth.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : ram_stream_reader_pkg

// File: rtl/ram_stream_reader_fifo.sv
// pix_fifo: small synchronous FIFO buffering RAM read data for the pixel stream.
// Push and pop may happen on the same edge; the count is then unchanged.
module pix_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DW-1:0]               push_data,
  input  logic                        pop,
  output logic [DW-1:0]               head,
  output logic [fifo_cw(DEPTH)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = fifo_cw(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Advance a pointer with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; contents are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule : pix_fifo

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads LEN consecutive words starting at BASE_ADDR from a
// single-port RAM with one-cycle registered-address latency and presents them
// as a valid/ready pixel stream. A two-entry FIFO hides the RAM latency so the
// stream sustains one beat per cycle while PIX_READY stays high.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int DW         = DEFAULT_DW,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [AW:0]   LEN,
  output logic [AW-1:0] A,
  output logic          WE,
  output logic          OE,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q,
  output logic [DW-1:0] PIX_DATA,
  output logic          PIX_VALID,
  input  logic          PIX_READY,
  output logic          PIX_LAST,
  output logic          BUSY,
  output logic          DONE
);

  localparam int CW = fifo_cw(FIFO_DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic          inflight_q, inflight_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   beat_cnt_q, beat_cnt_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;
  logic          pop;
  logic          issue;

  // Words held or already requested, net of the beat leaving this cycle.
  // A new read is issued only if its data is guaranteed a FIFO slot.
  assign pop       = PIX_VALID & PIX_READY;
  assign occupancy = (CW+1)'(fifo_cnt) + (CW+1)'(inflight_q) - (CW+1)'(pop);

  // Next-state logic for the sequencer, address generator and counters.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    inflight_d  = 1'b0;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    issue       = 1'b0;

    if (pop) beat_cnt_d = beat_cnt_q + (AW+1)'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          len_d       = LEN;
          remaining_d = LEN;
          beat_cnt_d  = '0;
          a_d         = BASE_ADDR;
          state_d     = (LEN == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        issue = (occupancy < (CW+1)'(FIFO_DEPTH)) && (remaining_q != '0);
        if (issue) begin
          inflight_d  = 1'b1;
          a_d         = a_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
          if (remaining_q == (AW+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish on the edge where the last buffered word leaves and nothing is arriving.
        if (!inflight_q && (fifo_cnt == CW'(pop))) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    oe_d   = (state_d == ST_READ) || (state_d == ST_DRAIN);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state, address, counters and registered control outputs.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      inflight_q  <= 1'b0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      inflight_q  <= inflight_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Read data arrives one cycle after its address was latched; capture it then.
  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (CK),
    .rst_n     (RST_N),
    .push      (inflight_q),
    .push_data (Q),
    .pop       (pop),
    .head      (PIX_DATA),
    .count     (fifo_cnt)
  );

  assign A         = a_q;
  assign OE        = oe_q;
  assign WE        = 1'b0;
  assign D         = '0;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PIX_VALID = (fifo_cnt != '0);
  assign PIX_LAST  = PIX_VALID && (beat_cnt_q == (len_q - (AW+1)'(1)));

endmodule : ram_stream_reader
